instr_sequencer: RTL

- Upstream feeder for the matrix coprocessor top.
- Holds a small program of 22-bit coprocessor instructions ({N0[1:0], N1[7:0], ID[1:0], LIN[2:0], COL[2:0], OP[3:0]}) and issues them one at a time on a start strobe.
- Runs in single-step mode (debounced button pulse) or auto-run mode; waits for the coprocessor to go idle before issuing the next word.
- Replaces hand-indexed instruction vectors in board bring-up.

---
 rtl/cop_pkg.sv | 52 +++++
 rtl/instr_sequencer_prog_ram.sv | 36 +++
 rtl/instr_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cop_pkg.sv
// Shared definitions for the coprocessor instruction sequencer.
// Instruction layout: {N0[1:0], N1[7:0], ID[1:0], LIN[2:0], COL[2:0], OP[3:0]}.
// Holds opcode constants, field slice positions, the instruction width,
// the sequencer state encoding and an opcode legality helper.
package cop_pkg;

  localparam int unsigned INSTR_W = 22;

  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_MSB  = 3;
  localparam int unsigned COL_LSB = 4;
  localparam int unsigned COL_MSB = 6;
  localparam int unsigned LIN_LSB = 7;
  localparam int unsigned LIN_MSB = 9;
  localparam int unsigned ID_LSB  = 10;
  localparam int unsigned ID_MSB  = 11;
  localparam int unsigned N1_LSB  = 12;
  localparam int unsigned N1_MSB  = 19;
  localparam int unsigned N0_LSB  = 20;
  localparam int unsigned N0_MSB  = 21;

  localparam logic [3:0] OP_HALT      = 4'h0;
  localparam logic [3:0] OP_STORE     = 4'h2;
  localparam logic [3:0] OP_SUM       = 4'h3;
  localparam logic [3:0] OP_SUB       = 4'h4;
  localparam logic [3:0] OP_MULT      = 4'h5;
  localparam logic [3:0] OP_TRANSPOSE = 4'h6;
  localparam logic [3:0] OP_OPPOSITE  = 4'h7;
  localparam logic [3:0] OP_SCALAR    = 4'h8;
  localparam logic [3:0] OP_DET2      = 4'h9;
  localparam logic [3:0] OP_DET3      = 4'hA;
  localparam logic [3:0] OP_DET4      = 4'hB;
  localparam logic [3:0] OP_DET5      = 4'hC;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT_BUSY = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_ADVANCE   = 4'd6,
    ST_HALT      = 4'd7,
    ST_ERR       = 4'd8
  } seq_state_e;

  // Legal opcodes form one contiguous range: STORE through DET5.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_STORE) && (op <= OP_DET5);
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// prog_ram: DEPTH x DW program store, synchronous write, synchronous read
// with one cycle of latency. Same-address read and write in one cycle
// returns the old word (read-before-write). Contents are not reset.
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address
//   o_rdata  out registered read data
module prog_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 22
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: holds a small program of coprocessor instructions and
// issues them one at a time, single-stepped by a button edge or
// back-to-back while run is high, waiting for the coprocessor to go idle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en/addr/data  program write port (accepted in IDLE or HALT only)
//   prog_len      number of valid program words, 0..DEPTH
//   step          rising edge issues one instruction
//   run           level; instructions issue back-to-back while high
//   cop_busy      coprocessor busy flag
//   instr_out     instruction presented to the coprocessor
//   instr_start   one-cycle issue strobe
//   pc            address of the current or next instruction
//   halted        program finished
//   err           illegal opcode seen; sticky until rst
module instr_sequencer
  import cop_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned BUSY_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW:0]        prog_len,
  input  logic               step,
  input  logic               run,
  input  logic               cop_busy,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_start,
  output logic [AW-1:0]      pc,
  output logic               halted,
  output logic               err
);

  localparam int unsigned CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  seq_state_e         r_state;
  seq_state_e         w_next;
  logic [AW-1:0]      r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_err;
  logic               r_step_d;
  logic               r_run_d;
  logic [CW-1:0]      r_wcnt;

  logic [INSTR_W-1:0] w_rdata;
  logic [3:0]         w_op;
  logic               w_step_rise;
  logic               w_run_rise;
  logic               w_wr_ok;
  logic [AW:0]        w_pc_inc;

  assign w_step_rise = step & ~r_step_d;
  assign w_run_rise  = run & ~r_run_d;
  assign w_wr_ok     = wr_en & ((r_state == ST_IDLE) | (r_state == ST_HALT));
  assign w_op        = w_rdata[OP_MSB:OP_LSB];
  // Compared in AW+1 bits so prog_len == DEPTH terminates on the last word.
  assign w_pc_inc    = {1'b0, r_pc} + (AW+1)'(1);

  // The RAM reads pc every cycle; the word seen in DECODE is the one
  // addressed during FETCH.
  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (INSTR_W)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_step_rise || run) begin
          w_next = (prog_len == '0) ? ST_HALT : ST_FETCH;
        end
      end
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_op == OP_HALT) begin
          w_next = ST_HALT;
        end else if (!op_is_legal(w_op)) begin
          w_next = ST_ERR;
        end else begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (cop_busy) begin
          w_next = ST_WAIT_DONE;
        end else if (r_wcnt == CW'(BUSY_WAIT - 1)) begin
          w_next = ST_ADVANCE;
        end
      end
      ST_WAIT_DONE: begin
        if (!cop_busy) begin
          w_next = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (w_pc_inc >= prog_len) begin
          w_next = ST_HALT;
        end else if (run) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (w_step_rise || w_run_rise) begin
          w_next = ST_IDLE;
        end
      end
      ST_ERR:  w_next = ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_err    <= 1'b0;
      r_step_d <= 1'b1;
      r_run_d  <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      r_state  <= w_next;
      r_step_d <= step;
      r_run_d  <= run;
      case (r_state)
        ST_DECODE: begin
          if (w_next == ST_ISSUE) begin
            r_instr <= w_rdata;
          end else if (w_next == ST_ERR) begin
            r_err <= 1'b1;
          end
        end
        ST_ISSUE: r_wcnt <= '0;
        ST_WAIT_BUSY: begin
          if (!cop_busy) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        // pc holds on the last word when the program ends, so it never
        // points past prog_len-1.
        ST_ADVANCE: begin
          if (w_next != ST_HALT) begin
            r_pc <= r_pc + 1'b1;
          end
        end
        ST_HALT: begin
          if (w_next == ST_IDLE) begin
            r_pc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_out   = r_instr;
  assign instr_start = (r_state == ST_ISSUE);
  assign pc          = r_pc;
  assign halted      = (r_state == ST_HALT);
  assign err         = r_err;

endmodule
